// File: rtl/wb_stage_if.sv
// Bus bundle between the MEM stage / mul-div unit and the writeback stage.
// The master side drives MEM results and mul/div results; the slave side is wb_stage.
interface wb_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    // MEM/WB pipeline inputs
    logic                  mem_valid;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [1:0]            mem_wb_sel;
    logic [2:0]            mem_funct3;
    logic [1:0]            mem_addr_lo;
    logic [XLEN-1:0]       mem_alu_result;
    logic [XLEN-1:0]       mem_load_word;
    logic [XLEN-1:0]       mem_pc_plus4;

    // Long-latency mul/div result channel
    logic                  md_valid;
    logic                  md_ready;
    logic [REG_ADDR_W-1:0] md_rd;
    logic [XLEN-1:0]       md_result;

    // Register-file write port
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       write_data;

    modport master (
        output mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_funct3,
               mem_addr_lo, mem_alu_result, mem_load_word, mem_pc_plus4,
               md_valid, md_rd, md_result,
        input  md_ready, reg_write, rd, write_data
    );

    modport slave (
        input  mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_funct3,
               mem_addr_lo, mem_alu_result, mem_load_word, mem_pc_plus4,
               md_valid, md_rd, md_result,
        output md_ready, reg_write, rd, write_data
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load formatting, and arbitration of the single
// register-file write port between the pipeline and a one-entry mul/div result buffer.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic       clk,
    input logic       reset_n,
    wb_stage_if.slave bus
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_type_e;

    // Output register and mul/div buffer state
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  buf_full_q, buf_full_d;
    logic [REG_ADDR_W-1:0] buf_rd_q, buf_rd_d;
    logic [XLEN-1:0]       buf_data_q, buf_data_d;

    logic                  pipe_wr;
    logic                  md_hs;
    logic                  md_keep;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       pipe_data;

    assign pipe_wr = bus.mem_valid && bus.mem_reg_write && (bus.mem_rd != '0);
    assign md_hs   = bus.md_valid && !buf_full_q;
    // Results aimed at x0 complete the handshake but are otherwise discarded.
    assign md_keep = md_hs && (bus.md_rd != '0);

    // NOTE: every signal driven in an always_comb gets a value on all paths (defaults
    // first or a default case arm); a missed path would infer a latch.
    always_comb begin
        unique case (bus.mem_addr_lo)
            2'd0:    ld_byte = bus.mem_load_word[7:0];
            2'd1:    ld_byte = bus.mem_load_word[15:8];
            2'd2:    ld_byte = bus.mem_load_word[23:16];
            default: ld_byte = bus.mem_load_word[31:24];
        endcase
        ld_half = bus.mem_addr_lo[1] ? bus.mem_load_word[31:16] : bus.mem_load_word[15:0];

        case (ld_type_e'(bus.mem_funct3))
            LD_LB:   load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            LD_LBU:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            LD_LH:   load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            LD_LHU:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = bus.mem_load_word;
        endcase
    end

    always_comb begin
        case (wb_sel_e'(bus.mem_wb_sel))
            WB_LOAD: pipe_data = load_data;
            WB_PC4:  pipe_data = bus.mem_pc_plus4;
            default: pipe_data = bus.mem_alu_result;
        endcase
    end

    // Write-port arbitration: pipeline, then buffered md result, then a fresh md result.
    always_comb begin
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        data_d      = data_q;
        buf_full_d  = buf_full_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;

        if (pipe_wr) begin
            reg_write_d = 1'b1;
            rd_d        = bus.mem_rd;
            data_d      = pipe_data;
            if (md_keep) begin
                buf_full_d = 1'b1;
                buf_rd_d   = bus.md_rd;
                buf_data_d = bus.md_result;
            end
        end else if (buf_full_q) begin
            reg_write_d = 1'b1;
            rd_d        = buf_rd_q;
            data_d      = buf_data_q;
            buf_full_d  = 1'b0;
        end else if (md_keep) begin
            reg_write_d = 1'b1;
            rd_d        = bus.md_rd;
            data_d      = bus.md_result;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            buf_full_q  <= 1'b0;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            buf_full_q  <= buf_full_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign bus.reg_write  = reg_write_q;
    assign bus.rd         = rd_q;
    assign bus.write_data = data_q;
    assign bus.md_ready   = !buf_full_q;

    a_no_x0_write: assert property (@(posedge clk) disable iff (!reset_n)
        reg_write_q |-> (rd_q != '0));

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected register-file writes are queued as stimulus
// is driven and consumed by a monitor whenever the write port fires.
module tb_wb_stage;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wr_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_vec_t;

    logic clk = 1'b0;
    logic reset_n;
    wr_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    ld_vec_t vec [17];

    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus ();

    wb_stage #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.mem_valid      = 1'b0;
        bus.mem_reg_write  = 1'b0;
        bus.mem_rd         = '0;
        bus.mem_wb_sel     = 2'b00;
        bus.mem_funct3     = 3'b010;
        bus.mem_addr_lo    = 2'b00;
        bus.mem_alu_result = 32'hA1A1_A1A1;
        bus.mem_load_word  = 32'h0;
        bus.mem_pc_plus4   = 32'h0000_1004;
        bus.md_valid       = 1'b0;
        bus.md_rd          = '0;
        bus.md_result      = 32'h0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val);
        bus.mem_valid      = 1'b1;
        bus.mem_reg_write  = 1'b1;
        bus.mem_rd         = rd;
        bus.mem_wb_sel     = 2'b00;
        bus.mem_alu_result = val;
    endtask

    task automatic drive_md(input logic [4:0] rd, input logic [31:0] val);
        bus.md_valid  = 1'b1;
        bus.md_rd     = rd;
        bus.md_result = val;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] val);
        sb.push_back('{rd: rd, data: val});
    endtask

    // Monitor: every write-port pulse must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.reg_write === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(bus.reg_write), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("wr_rd", 32'(bus.rd), 32'(e.rd));
                    check("wr_data", bus.write_data, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec = '{
            '{2'b01, 3'b000, 2'd2, 32'h1280_3456, 32'hFFFF_FF80},
            '{2'b01, 3'b100, 2'd2, 32'h1280_3456, 32'h0000_0080},
            '{2'b01, 3'b001, 2'd2, 32'h1280_3456, 32'h0000_1280},
            '{2'b01, 3'b101, 2'd2, 32'h1280_3456, 32'h0000_1280},
            '{2'b01, 3'b010, 2'd2, 32'h1280_3456, 32'h1280_3456},
            '{2'b01, 3'b000, 2'd3, 32'h1280_3456, 32'h0000_0012},
            '{2'b01, 3'b100, 2'd1, 32'h1280_3456, 32'h0000_0034},
            '{2'b01, 3'b001, 2'd3, 32'h1280_3456, 32'h0000_1280},
            '{2'b01, 3'b001, 2'd0, 32'h8000_FF7F, 32'hFFFF_FF7F},
            '{2'b01, 3'b101, 2'd1, 32'h8000_FF7F, 32'h0000_FF7F},
            '{2'b01, 3'b001, 2'd2, 32'h8000_FF7F, 32'hFFFF_8000},
            '{2'b01, 3'b000, 2'd1, 32'h8000_FF7F, 32'hFFFF_FFFF},
            '{2'b01, 3'b100, 2'd0, 32'h8000_FF7F, 32'h0000_007F},
            '{2'b01, 3'b011, 2'd2, 32'h8000_FF7F, 32'h8000_FF7F},
            '{2'b10, 3'b000, 2'd0, 32'h8000_FF7F, 32'h0000_1004},
            '{2'b11, 3'b000, 2'd0, 32'h8000_FF7F, 32'hA1A1_A1A1},
            '{2'b00, 3'b000, 2'd0, 32'h8000_FF7F, 32'hA1A1_A1A1}
        };

        // Reset held while a valid pipeline write is presented
        reset_n = 1'b1;
        drive_idle();
        #2 reset_n = 1'b0;
        drive_alu(5'd3, 32'h5);
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_write", 32'(bus.reg_write), 32'h0);
        check("rst_rd", 32'(bus.rd), 32'h0);
        check("rst_write_data", bus.write_data, 32'h0);
        check("rst_md_ready", 32'(bus.md_ready), 32'h1);
        reset_n = 1'b1;
        expect_wr(5'd3, 32'h5);
        step();
        check("first_wr_latency", 32'(bus.reg_write), 32'h1);
        drive_idle();
        step();
        check("idle_after_first", 32'(bus.reg_write), 32'h0);

        // Load formatting and result-source selection
        for (int i = 0; i < 17; i++) begin
            drive_idle();
            bus.mem_valid     = 1'b1;
            bus.mem_reg_write = 1'b1;
            bus.mem_rd        = 5'(i + 1);
            bus.mem_wb_sel    = vec[i].sel;
            bus.mem_funct3    = vec[i].f3;
            bus.mem_addr_lo   = vec[i].lo;
            bus.mem_load_word = vec[i].word;
            expect_wr(5'(i + 1), vec[i].exp);
            step();
        end
        drive_idle();
        step();

        // Lone md result passes straight through
        drive_md(5'd7, 32'hDEAD_BEEF);
        expect_wr(5'd7, 32'hDEAD_BEEF);
        step();
        check("md_pass_ready", 32'(bus.md_ready), 32'h1);
        check("md_pass_wr", 32'(bus.reg_write), 32'h1);
        drive_idle();
        step();
        check("hold_reg_write", 32'(bus.reg_write), 32'h0);
        check("hold_rd", 32'(bus.rd), 32'd7);
        check("hold_data", bus.write_data, 32'hDEAD_BEEF);

        // Simultaneous pipeline and md results: md is buffered then drained
        drive_alu(5'd5, 32'h11);
        drive_md(5'd9, 32'h22);
        expect_wr(5'd5, 32'h11);
        expect_wr(5'd9, 32'h22);
        step();
        check("buf_md_ready", 32'(bus.md_ready), 32'h0);
        drive_idle();
        step();
        check("drain_wr", 32'(bus.reg_write), 32'h1);
        check("drain_rd", 32'(bus.rd), 32'd9);
        step();
        check("drain_md_ready", 32'(bus.md_ready), 32'h1);

        // x0 destinations from both sources are dropped
        drive_alu(5'd0, 32'h33);
        drive_md(5'd0, 32'h44);
        step();
        check("x0_wr_a", 32'(bus.reg_write), 32'h0);
        check("x0_ready_a", 32'(bus.md_ready), 32'h1);
        drive_idle();
        step();
        check("x0_wr_b", 32'(bus.reg_write), 32'h0);
        check("x0_ready_b", 32'(bus.md_ready), 32'h1);
        drive_alu(5'd4, 32'h55);
        drive_md(5'd0, 32'h66);
        expect_wr(5'd4, 32'h55);
        step();
        check("x0_md_not_buffered", 32'(bus.md_ready), 32'h1);
        drive_idle();
        step();
        check("x0_no_drain", 32'(bus.reg_write), 32'h0);

        // Buffer held behind continuous pipeline writes, then cleared by reset
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            drive_alu(5'(i + 1), 32'h100 + 32'(i));
            if (i == 0) drive_md(5'd9, 32'h99);
            if (i >= 2) drive_md(5'd12, 32'hCC);
            expect_wr(5'(i + 1), 32'h100 + 32'(i));
            step();
            check("busy_md_ready", 32'(bus.md_ready), 32'h0);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        drive_idle();
        #1;
        check("midrst_reg_write", 32'(bus.reg_write), 32'h0);
        check("midrst_rd", 32'(bus.rd), 32'h0);
        check("midrst_data", bus.write_data, 32'h0);
        check("midrst_md_ready", 32'(bus.md_ready), 32'h1);
        #1 reset_n = 1'b1;
        repeat (6) step();
        check("post_rst_no_x9", 32'(bus.reg_write), 32'h0);
        check("post_rst_ready", 32'(bus.md_ready), 32'h1);

        @(negedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
